// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encodings and stage-register layout for the
// memory-access stage.
package mem_access_pkg;

  localparam logic [7:0] EXE_OP_NOP = 8'b0000_0000;
  localparam logic [7:0] EXE_OP_OR  = 8'b0010_0101;
  localparam logic [7:0] EXE_OP_LB  = 8'b1110_0000;
  localparam logic [7:0] EXE_OP_LH  = 8'b1110_0001;
  localparam logic [7:0] EXE_OP_LW  = 8'b1110_0011;
  localparam logic [7:0] EXE_OP_LBU = 8'b1110_0100;
  localparam logic [7:0] EXE_OP_LHU = 8'b1110_0101;
  localparam logic [7:0] EXE_OP_SB  = 8'b1110_1000;
  localparam logic [7:0] EXE_OP_SH  = 8'b1110_1001;
  localparam logic [7:0] EXE_OP_SW  = 8'b1110_1011;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_BUS  = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;

  localparam int DBUS_SEL_W = 4;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        we;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } stage_t;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_OP_LB, EXE_OP_LBU, EXE_OP_LH, EXE_OP_LHU, EXE_OP_LW};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_OP_SB, EXE_OP_SH, EXE_OP_SW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering: bus select, store replication,
// load extraction/extension and misalignment detection.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [7:0]            aluop,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           store_data,
  input  logic [31:0]           rdata,
  output logic [DBUS_SEL_W-1:0] sel,
  output logic [31:0]           wdata,
  output logic [31:0]           load_data,
  output logic                  misaligned
);

  logic [3:0][7:0] lanes;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [3:0]      half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign rd_byte  = lanes[addr_lo];
  assign rd_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign half_sel = addr_lo[1] ? 4'b1100 : 4'b0011;

  always_comb begin
    sel        = '0;
    wdata      = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (aluop)
      EXE_OP_LB: begin
        sel       = 4'b0001 << addr_lo;
        load_data = {{24{rd_byte[7]}}, rd_byte};
      end
      EXE_OP_LBU: begin
        sel       = 4'b0001 << addr_lo;
        load_data = {24'd0, rd_byte};
      end
      EXE_OP_LH: begin
        sel        = half_sel;
        misaligned = addr_lo[0];
        load_data  = {{16{rd_half[15]}}, rd_half};
      end
      EXE_OP_LHU: begin
        sel        = half_sel;
        misaligned = addr_lo[0];
        load_data  = {16'd0, rd_half};
      end
      EXE_OP_LW: begin
        sel        = 4'b1111;
        misaligned = |addr_lo;
        load_data  = rdata;
      end
      EXE_OP_SB: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      EXE_OP_SH: begin
        sel        = half_sel;
        misaligned = addr_lo[0];
        wdata      = {2{store_data[15:0]}};
      end
      EXE_OP_SW: begin
        sel        = 4'b1111;
        misaligned = |addr_lo;
        wdata      = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// EX/MEM stage register plus a req/ack load/store engine that stalls the
// pipeline while a data-bus transaction is outstanding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ex_wdata,
  input  logic [4:0]            ex_waddr,
  input  logic                  ex_we,
  input  logic [7:0]            ex_aluop,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_mem_data,
  input  logic                  stall_i,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [DBUS_SEL_W-1:0] dbus_sel,
  output logic [31:0]           dbus_addr,
  output logic [31:0]           dbus_wdata,
  input  logic [31:0]           dbus_rdata,
  input  logic                  dbus_ack,
  output logic [31:0]           wb_wdata,
  output logic [4:0]            wb_waddr,
  output logic                  wb_we,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  stage_t           stage_q, stage_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;
  logic             fired_q, fired_d;

  logic                  op_load, op_store, op_mem, hold;
  logic                  in_bus, in_done;
  logic [DBUS_SEL_W-1:0] al_sel;
  logic [31:0]           al_wdata, al_load;
  logic                  al_mis;

  mem_align u_align (
    .aluop      (stage_q.aluop),
    .addr_lo    (stage_q.mem_addr[1:0]),
    .store_data (stage_q.mem_data),
    .rdata      (rdata_q),
    .sel        (al_sel),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  assign op_load  = is_load(stage_q.aluop);
  assign op_store = is_store(stage_q.aluop);
  assign op_mem   = op_load | op_store;
  assign in_bus   = (state_q == MEM_BUS);
  assign in_done  = (state_q == MEM_DONE);

  assign stallreq_o = op_mem & ~in_done;
  assign hold       = stallreq_o | stall_i;

  always_comb begin
    stage_d = stage_q;
    if (!hold) begin
      stage_d.wdata    = ex_wdata;
      stage_d.waddr    = ex_waddr;
      stage_d.we       = ex_we;
      stage_d.aluop    = ex_aluop;
      stage_d.mem_addr = ex_mem_addr;
      stage_d.mem_data = ex_mem_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    fired_d = fired_q;
    case (state_q)
      MEM_IDLE: begin
        fired_d = 1'b0;
        if (op_mem) begin
          mis_d   = al_mis;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = al_mis ? MEM_DONE : MEM_BUS;
        end
      end
      MEM_BUS: begin
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = MEM_DONE;
        end else begin
          // Saturating so a disabled timeout can never wrap into a false abort.
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = MEM_DONE;
          end
        end
      end
      MEM_DONE: begin
        fired_d = 1'b1;
        if (!stall_i) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q       <= '0;
      stage_q.aluop <= EXE_OP_NOP;
      state_q       <= MEM_IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      mis_q         <= 1'b0;
      err_q         <= 1'b0;
      fired_q       <= 1'b0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      fired_q <= fired_d;
    end
  end

  // Bus fields are driven only in BUS; stage hold keeps them stable there.
  always_comb begin
    dbus_req   = in_bus;
    dbus_we    = in_bus & op_store;
    dbus_sel   = in_bus ? al_sel : '0;
    dbus_addr  = in_bus ? {stage_q.mem_addr[31:2], 2'b00} : '0;
    dbus_wdata = in_bus ? al_wdata : '0;
  end

  always_comb begin
    wb_waddr = stage_q.waddr;
    wb_wdata = stage_q.wdata;
    wb_we    = 1'b0;
    if (!op_mem) begin
      wb_we = stage_q.we;
    end else if (in_done && op_load && !mis_q && !err_q) begin
      wb_we    = 1'b1;
      wb_wdata = al_load;
    end
  end

  assign misalign_o = in_done & mis_q & ~fired_q;
  assign bus_err_o  = in_done & err_q & ~fired_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Downstream neighbour of the execute stage: EX/MEM stage register plus load/store engine.
- Latches the execute results (write data, write address, write enable, ALU op, memory address, store data).
- Non-memory ops pass through to write-back. Loads and stores run a req/ack transaction on the data bus, and the stage requests a pipeline stall until the transaction completes.
- Output feeds the MEM/WB register and regfile write port. Stall request goes to the pipeline control block.

Parameters:
- TIMEOUT, 16, max cycles waiting for dbus_ack before abort; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1)
- ex_wdata  in  32  execute result
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_aluop  in  8  ALU op code (RegBus/AluOpBus widths from Defines.v)
- ex_mem_addr  in  32  effective address for loads/stores
- ex_mem_data  in  32  store data (rt)
- stall_i  in  1  stall from pipeline control (stage holds)
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_sel  out  4  byte lanes, little-endian
- dbus_addr  out  32  word address, bits[1:0] = 0
- dbus_wdata  out  32  store data, lane-replicated
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  transaction complete
- wb_wdata  out  32  write-back data
- wb_waddr  out  5  write-back address
- wb_we  out  1  write-back enable
- stallreq_o  out  1  stall request to control
- misalign_o  out  1  one-cycle pulse, misaligned access dropped
- bus_err_o  out  1  one-cycle pulse, bus timeout

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - stage register cleared (op = NOP, we = 0).
  - FSM goes to IDLE.
  - All outputs 0.
- Stage register:
  - Captures all ex_* inputs when hold = stallreq_o | stall_i is 0.
  - Otherwise holds its value.
- Non-memory op (not LB/LBU/LH/LHU/LW/SB/SH/SW):
  - wb_* = stored values, combinationally.
  - stallreq_o = 0; no bus activity.
- FSM states: IDLE, BUS, DONE.
  - IDLE, memory op stored:
    - If misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to DONE with the misalign flag set; no bus access.
    - Otherwise go to BUS; the timeout counter clears.
    - stallreq_o = 1 throughout IDLE.
  - BUS:
    - dbus_req = 1; dbus_we/sel/addr/wdata are held stable.
    - stallreq_o = 1.
    - On dbus_ack: capture dbus_rdata, go to DONE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT > 0), go to DONE with the error flag set.
  - DONE:
    - stallreq_o = 0 and dbus_req = 0.
    - Outputs this cycle:
      - load: wb_we = 1, wb_wdata = extracted and extended data.
      - store: wb_we = 0.
      - flagged: wb_we = 0; misalign_o or bus_err_o = 1.
    - If stall_i = 1: stay in DONE with outputs held; pulses fire only on the first DONE cycle.
    - Else return to IDLE while the stage register loads the next instruction.
- While stallreq_o = 1, wb_we is forced to 0 (the bubble is inserted downstream).
- Byte lanes:
  - LB/LBU/SB: sel = 1 << addr[1:0].
  - LH/LHU/SH: sel = addr[1] ? 4'b1100 : 4'b0011.
  - LW/SW: sel = 4'b1111.
- Store data: SB = {4{d[7:0]}}, SH = {2{d[15:0]}}, SW = d.
- Load extract: select the addressed byte/halfword. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency: a load with ack in the first BUS cycle completes in 3 stage cycles (IDLE, BUS, DONE). Each extra ack-wait cycle adds one.
- Boundary cases:
  - dbus_ack outside BUS is ignored.
  - Reset in BUS drops dbus_req at that edge; a later ack is ignored.
  - stall_i during IDLE/BUS does not pause the FSM, since the bus transaction is owned by this stage.
  - Counter saturates and never wraps.

Decomposition:
- Defines.v additions: op codes EXE_OP_LB/LBU/LH/LHU/LW/SB/SH/SW; state encodings MEM_IDLE/MEM_BUS/MEM_DONE; DBusSelBus width.
- Sub-module mem_align: purely combinational; takes (aluop, addr[1:0], store data, rdata) and produces (sel, wdata, load result, misaligned).

Test Plan:
- ORI result 0x0000FFFF, waddr=3, we=1 -> next cycle wb_wdata=0x0000FFFF, wb_waddr=3, wb_we=1, stallreq_o=0, dbus_req never 1.
- LB addr=0x103, rdata=0x80112233, ack in 1st BUS cycle -> sel=4'b1000, dbus_addr=0x100, DONE wb_wdata=0xFFFFFF80, wb_we=1; total stall 2 cycles.
- SH addr=0x202, data=0x0000BEEF, ack after 3 wait cycles -> dbus_we=1, sel=4'b1100, wdata=0xBEEFBEEF held stable 4 cycles; DONE wb_we=0.
- LW addr=0x301 -> no dbus_req, misalign_o=1 for exactly 1 cycle, wb_we=0, pipeline resumes.
- LW with no ack, TIMEOUT=16 -> dbus_req high 16 cycles, bus_err_o pulse, wb_we=0; late ack ignored.
- rst=1 in BUS, then ack next cycle -> dbus_req=0 after the edge, all outputs 0, FSM IDLE, no write-back.
